// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing generator.
`timescale 1ns/1ps
package video_timing_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    localparam int DEF_LINE_MIN  = 246;
    localparam int DEF_LINE_MAX  = 262;
    localparam int DEF_HALF_MIN  = 200;
    localparam int DEF_LOCK_GOOD = 8;
    localparam int DEF_LOCK_BAD  = 4;

    localparam logic [8:0] COL_SAT = 9'd511;

    // A saturated column counter never describes a real line period.
    function automatic logic period_legal(input logic [8:0] col, input int lmin, input int lmax);
        int period_v;
        period_v = int'(col) + 32'sd1;
        return (col != COL_SAT) && (period_v >= lmin) && (period_v <= lmax);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses; idles high in reset.
`timescale 1ns/1ps
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic meta_r;
    logic sync_r;
    logic dly_r;
    logic rise_r;
    logic fall_r;

    // Synchronizer chain plus edge detect; dly_r is the level aligned with the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            dly_r  <= 1'b1;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            dly_r  <= sync_r;
            rise_r <= sync_r & ~dly_r;
            fall_r <= ~sync_r & dly_r;
        end
    end

    assign level      = dly_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;

endmodule

// File: rtl/video_timing_gen.sv
// Line/field timing recovery from composite sync with a line-period lock detector.
`timescale 1ns/1ps
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int LINE_MIN  = DEF_LINE_MIN,
    parameter int LINE_MAX  = DEF_LINE_MAX,
    parameter int HALF_MIN  = DEF_HALF_MIN,
    parameter int LOCK_GOOD = DEF_LOCK_GOOD,
    parameter int LOCK_BAD  = DEF_LOCK_BAD
) (
    input  logic       clk4mhz,
    input  logic       reset_n,
    input  logic       csync,
    input  logic       vsync,
    input  logic       field,
    output logic [8:0] col_cnt,
    output logic [8:0] line_cnt,
    output logic       line_start,
    output logic       field_start,
    output logic       field_id,
    output logic       active,
    output logic       locked
);

    logic csync_lvl_s, csync_rise_s, csync_fall_s;
    logic vsync_lvl_s, vsync_rise_s, vsync_fall_s;
    logic field_lvl_s, field_rise_s, field_fall_s;
    logic unused_edges_s;

    sync_edge u_sync_csync (.clk(clk4mhz), .rst_n(reset_n), .async_in(csync),
                            .level(csync_lvl_s), .rise_pulse(csync_rise_s), .fall_pulse(csync_fall_s));
    sync_edge u_sync_vsync (.clk(clk4mhz), .rst_n(reset_n), .async_in(vsync),
                            .level(vsync_lvl_s), .rise_pulse(vsync_rise_s), .fall_pulse(vsync_fall_s));
    sync_edge u_sync_field (.clk(clk4mhz), .rst_n(reset_n), .async_in(field),
                            .level(field_lvl_s), .rise_pulse(field_rise_s), .fall_pulse(field_fall_s));

    assign unused_edges_s = ^{csync_rise_s, vsync_fall_s, field_rise_s, field_fall_s};

    logic [8:0]  col_cnt_r;
    logic [8:0]  line_cnt_r;
    logic        line_start_r;
    logic        field_id_r;
    logic        active_r;
    logic        locked_r;
    lock_state_e state_r, state_nxt_s;
    logic [2:0]  good_r, good_nxt_s;
    logic [2:0]  bad_r, bad_nxt_s;

    logic accept_s;
    logic qualify_s;
    logic good_line_s;
    logic bad_line_s;
    logic sat_evt_s;

    // Short edges (equalizing/serration) are ignored; a start at 511 was already
    // charged as illegal when the counter saturated, so it is not qualified again.
    assign accept_s    = csync_fall_s && ((int'(col_cnt_r) >= HALF_MIN) || (col_cnt_r == COL_SAT));
    assign qualify_s   = accept_s && vsync_lvl_s && (col_cnt_r != COL_SAT);
    assign good_line_s = qualify_s && period_legal(col_cnt_r, LINE_MIN, LINE_MAX);
    assign sat_evt_s   = !accept_s && (col_cnt_r == 9'd510);
    assign bad_line_s  = (qualify_s && !period_legal(col_cnt_r, LINE_MIN, LINE_MAX)) || sat_evt_s;

    // Lock FSM next-state and good/bad counter update.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_r;
        bad_nxt_s   = bad_r;
        case (state_r)
            ST_SEARCH: begin
                if (good_line_s) begin
                    state_nxt_s = ST_LOCKING;
                    good_nxt_s  = 3'd1;
                    bad_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_LOCKING: begin
                if (good_line_s) begin
                    if (int'(good_r) + 32'sd1 >= LOCK_GOOD) begin
                        state_nxt_s = ST_LOCKED;
                        good_nxt_s  = 3'd0;
                        bad_nxt_s   = 3'd0;
                    end else begin
                        good_nxt_s = good_r + 3'd1;
                    end
                end else if (bad_line_s) begin
                    state_nxt_s = ST_SEARCH;
                    good_nxt_s  = 3'd0;
                end else begin
                    state_nxt_s = ST_LOCKING;
                end
            end
            ST_LOCKED: begin
                if (bad_line_s) begin
                    if (int'(bad_r) + 32'sd1 >= LOCK_BAD) begin
                        state_nxt_s = ST_SEARCH;
                        good_nxt_s  = 3'd0;
                        bad_nxt_s   = 3'd0;
                    end else begin
                        bad_nxt_s = bad_r + 3'd1;
                    end
                end else if (good_line_s) begin
                    bad_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_SEARCH;
                good_nxt_s  = 3'd0;
                bad_nxt_s   = 3'd0;
            end
        endcase
    end

    // Column/line counters, output pulses and lock state registers.
    always_ff @(posedge clk4mhz or negedge reset_n) begin
        if (!reset_n) begin
            col_cnt_r    <= COL_SAT;
            line_cnt_r   <= 9'd0;
            line_start_r <= 1'b0;
            field_id_r   <= 1'b0;
            active_r     <= 1'b0;
            locked_r     <= 1'b0;
            state_r      <= ST_SEARCH;
            good_r       <= 3'd0;
            bad_r        <= 3'd0;
        end else begin
            if (accept_s) begin
                col_cnt_r <= 9'd0;
            end else if (col_cnt_r != COL_SAT) begin
                col_cnt_r <= col_cnt_r + 9'd1;
            end
            line_start_r <= accept_s;
            // Field start clears the line count even when a line start lands with it.
            if (vsync_rise_s) begin
                line_cnt_r <= 9'd0;
                field_id_r <= field_lvl_s;
            end else if (line_start_r && vsync_lvl_s && (line_cnt_r != 9'd511)) begin
                line_cnt_r <= line_cnt_r + 9'd1;
            end
            active_r <= vsync_lvl_s & csync_lvl_s;
            locked_r <= (state_nxt_s == ST_LOCKED);
            state_r  <= state_nxt_s;
            good_r   <= good_nxt_s;
            bad_r    <= bad_nxt_s;
        end
    end

    assign col_cnt     = col_cnt_r;
    assign line_cnt    = line_cnt_r;
    assign line_start  = line_start_r;
    assign field_start = vsync_rise_s;
    assign field_id    = field_id_r;
    assign active      = active_r;
    assign locked      = locked_r;

endmodule
